// File: rtl/uart_tx_fifo_if.sv
// uart_tx_fifo_if: valid/ready push channel into the UART TX FIFO.
//   tx_valid  producer -> FIFO   push request
//   tx_data   producer -> FIFO   word to queue (DATA_W bits)
//   tx_ready  FIFO -> producer   FIFO can accept this cycle
// master: the producer (CPU-side bus); slave: the FIFO.
interface uart_tx_fifo_if #(
  parameter int DATA_W = 8
);
  logic              tx_valid;
  logic [DATA_W-1:0] tx_data;
  logic              tx_ready;

  modport master (output tx_valid, output tx_data, input tx_ready);
  modport slave  (input tx_valid, input tx_data, output tx_ready);
endinterface

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: UART transmitter with runtime baud divisor, optional even/odd
// parity and 1/2 stop bits, fed by a small TX FIFO so the bus can queue bytes.
// Ports:
//   clk, reset   system clock; asynchronous active-high reset
//   tx_if        valid/ready push channel (slave side)
//   baud_div     clocks per bit minus 1 (sampled at frame start)
//   parity_en    append parity bit; parity_odd selects odd (1) / even (0)
//   stop2        two stop bits when set
//   fifo_count   entries currently queued
//   tx_busy      transmitter not idle
//   tx_end       one-cycle pulse when the last stop bit completes
//   tx           UART TX pin, registered, idle high
module uart_tx_fifo #(
  parameter int DATA_W     = 8,
  parameter int DIV_W      = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 3
) (
  input  logic             clk,
  input  logic             reset,
  uart_tx_fifo_if.slave    tx_if,
  input  logic [DIV_W-1:0] baud_div,
  input  logic             parity_en,
  input  logic             parity_odd,
  input  logic             stop2,
  output logic [CNT_W-1:0] fifo_count,
  output logic             tx_busy,
  output logic             tx_end,
  output logic             tx
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int IDX_W = $clog2(DATA_W);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t            state, state_n;
  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  count;
  logic [DIV_W-1:0]  div_cnt, cfg_div;
  logic              cfg_par_en, cfg_stop2;
  logic              par_bit, stop_cnt;
  logic [DATA_W-1:0] shift;
  logic [IDX_W-1:0]  bit_idx;
  logic              tx_q, tx_end_q;

  logic              push, pop, fifo_ne, bit_end, tx_n, end_n;
  logic [DATA_W-1:0] head;

  assign fifo_ne        = (count != '0);
  assign tx_if.tx_ready = (count != CNT_W'(FIFO_DEPTH));
  assign push           = tx_if.tx_valid && tx_if.tx_ready;
  assign bit_end        = (div_cnt == '0);
  assign head           = mem[rd_ptr];

  assign fifo_count = count;
  assign tx_busy    = (state != IDLE);
  assign tx_end     = tx_end_q;
  assign tx         = tx_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // tx is computed one bit ahead so that the registered pin changes on the
  // same edge the FSM enters the bit it belongs to.
  always_comb begin
    state_n = state;
    pop     = 1'b0;
    tx_n    = tx_q;
    end_n   = 1'b0;
    case (state)
      IDLE: begin
        tx_n = 1'b1;
        if (fifo_ne) begin
          pop     = 1'b1;
          tx_n    = 1'b0;
          state_n = START;
        end
      end
      START: begin
        if (bit_end) begin
          state_n = DATA;
          tx_n    = shift[0];
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bit_idx == LAST_IDX) begin
            if (cfg_par_en) begin
              state_n = PARITY;
              tx_n    = par_bit;
            end else begin
              state_n = STOP;
              tx_n    = 1'b1;
            end
          end else begin
            tx_n = shift[1];
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          state_n = STOP;
          tx_n    = 1'b1;
        end
      end
      STOP: begin
        if (bit_end && (stop_cnt || !cfg_stop2)) begin
          end_n = 1'b1;
          if (fifo_ne) begin
            pop     = 1'b1;
            tx_n    = 1'b0;
            state_n = START;
          end else begin
            state_n = IDLE;
            tx_n    = 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= tx_if.tx_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      div_cnt    <= '0;
      cfg_div    <= '0;
      cfg_par_en <= 1'b0;
      cfg_stop2  <= 1'b0;
      par_bit    <= 1'b0;
      stop_cnt   <= 1'b0;
      shift      <= '0;
      bit_idx    <= '0;
      tx_q       <= 1'b1;
      tx_end_q   <= 1'b0;
    end else begin
      tx_q     <= tx_n;
      tx_end_q <= end_n;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (pop) begin
        // Frame configuration is captured here and held until the next pop.
        shift      <= head;
        par_bit    <= (^head) ^ parity_odd;
        cfg_div    <= baud_div;
        cfg_par_en <= parity_en;
        cfg_stop2  <= stop2;
        div_cnt    <= baud_div;
        stop_cnt   <= 1'b0;
        bit_idx    <= '0;
      end else if (state != IDLE) begin
        if (bit_end) begin
          div_cnt <= cfg_div;
          if (state == DATA) begin
            shift   <= shift >> 1;
            bit_idx <= bit_idx + 1'b1;
          end
          if (state == STOP) stop_cnt <= 1'b1;
        end else begin
          div_cnt <= div_cnt - 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
module tb_uart_tx_fifo;
  localparam int DATA_W = 8;
  localparam int DIV_W  = 16;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = 3;

  logic             clk = 1'b0;
  logic             reset;
  logic [DIV_W-1:0] baud_div;
  logic             parity_en, parity_odd, stop2;
  logic [CNT_W-1:0] fifo_count;
  logic             tx_busy, tx_end, tx;

  always #5 clk = ~clk;

  uart_tx_fifo_if #(.DATA_W(DATA_W)) bus ();

  uart_tx_fifo #(
    .DATA_W(DATA_W), .DIV_W(DIV_W), .FIFO_DEPTH(DEPTH), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset), .tx_if(bus),
    .baud_div(baud_div), .parity_en(parity_en), .parity_odd(parity_odd),
    .stop2(stop2), .fifo_count(fifo_count), .tx_busy(tx_busy),
    .tx_end(tx_end), .tx(tx)
  );

  int checks = 0;
  int passes = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic fail_timeout(input string name);
    checks++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  // Reference model: FIFO as a queue of words, the current frame as a queue of
  // line levels, each held for (divisor+1) clocks.
  logic [DATA_W-1:0] m_q[$];
  bit                m_bits[$];
  int                m_rem, m_div;
  bit                m_end, m_acc, m_tx;
  logic [6:0]        m_act, m_exp;

  task automatic start_frame(input logic [DATA_W-1:0] w);
    m_div = int'(baud_div);
    m_rem = m_div + 1;
    m_bits.delete();
    m_bits.push_back(1'b0);
    for (int i = 0; i < DATA_W; i++) m_bits.push_back(w[i]);
    if (parity_en) m_bits.push_back((($countones(w) % 2) == 1) ^ parity_odd);
    m_bits.push_back(1'b1);
    if (stop2) m_bits.push_back(1'b1);
  endtask

  always @(posedge clk) begin
    if (reset) begin
      m_q.delete();
      m_bits.delete();
      m_rem = 0;
      m_end = 1'b0;
    end else begin
      m_end = 1'b0;
      m_acc = bus.tx_valid && (m_q.size() < DEPTH);
      if (m_bits.size() != 0) begin
        m_rem--;
        if (m_rem == 0) begin
          m_bits.delete(0);
          if (m_bits.size() == 0) m_end = 1'b1;
          else m_rem = m_div + 1;
        end
      end
      if (m_bits.size() == 0 && m_q.size() != 0) start_frame(m_q.pop_front());
      if (m_acc) m_q.push_back(bus.tx_data);
    end
    #1;
    m_tx  = (m_bits.size() != 0) ? m_bits[0] : 1'b1;
    m_exp = {m_tx, m_end, m_bits.size() != 0, m_q.size() != DEPTH, CNT_W'(m_q.size())};
    m_act = {tx, tx_end, tx_busy, bus.tx_ready, fifo_count};
    check("cycle {tx,end,busy,ready,count}", int'(m_act), int'(m_exp));
  end

  // Captures one frame: line level at the start of each bit time, and the
  // number of clocks from the falling start edge to the tx_end pulse.
  task automatic run_frame(input bit cont, input int div, output int len,
                           output logic [15:0] bits, output int waited);
    len = -1; bits = '0; waited = 0;
    if (!cont) begin
      do begin
        @(posedge clk); #1; waited++;
      end while (tx !== 1'b0 && waited < 400);
      if (tx !== 1'b0) begin
        fail_timeout("frame_start");
        return;
      end
    end
    bits[0] = tx;
    for (int k = 1; k <= 3000; k++) begin
      @(posedge clk); #1;
      if (tx_end === 1'b1) begin
        len = k;
        break;
      end
      if ((k % (div + 1)) == 0 && (k / (div + 1)) < 16) bits[k / (div + 1)] = tx;
    end
    if (len < 0) fail_timeout("frame_end");
  endtask

  task automatic push1(input logic [7:0] w);
    @(negedge clk); bus.tx_valid = 1'b1; bus.tx_data = w;
    @(negedge clk); bus.tx_valid = 1'b0;
  endtask

  int          l1, l2, w1, w2, n_end, n_low;
  logic [15:0] b1, b2;
  bit          e1;

  initial begin
    reset = 1'b1; bus.tx_valid = 1'b0; bus.tx_data = '0;
    baud_div = 16'd3; parity_en = 1'b0; parity_odd = 1'b0; stop2 = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_tx", tx, 1);
    check("reset_busy", tx_busy, 0);
    check("reset_ready", bus.tx_ready, 1);
    check("reset_count", fifo_count, 0);
    check("reset_end", tx_end, 0);
    reset = 1'b0;

    // 8N1, div=3
    push1(8'h55);
    run_frame(0, 3, l1, b1, w1);
    check("t1_latency", w1, 1);
    check("t1_len", l1, 40);
    check("t1_bits", int'(b1[9:0]), 'h2AA);
    check("t1_busy_at_end", tx_busy, 0);
    check("t1_tx_at_end", tx, 1);

    // parity even then odd, div=0
    @(negedge clk); baud_div = 16'd0; parity_en = 1'b1; parity_odd = 1'b0;
    push1(8'h07);
    run_frame(0, 0, l1, b1, w1);
    check("t2_even_len", l1, 11);
    check("t2_even_bits", int'(b1[10:0]), 'h60E);
    @(negedge clk); parity_odd = 1'b1;
    push1(8'h07);
    run_frame(0, 0, l1, b1, w1);
    check("t2_odd_len", l1, 11);
    check("t2_odd_bits", int'(b1[10:0]), 'h40E);

    // two stop bits, back-to-back frames, div=1
    @(negedge clk); baud_div = 16'd1; parity_odd = 1'b0; stop2 = 1'b1;
    fork
      begin
        @(negedge clk); bus.tx_valid = 1'b1; bus.tx_data = 8'hA5;
        @(negedge clk); bus.tx_data = 8'h3C;
        @(negedge clk); bus.tx_valid = 1'b0;
      end
      begin
        run_frame(0, 1, l1, b1, w1);
        e1 = tx;
        run_frame(1, 1, l2, b2, w2);
      end
    join
    check("t3_f1_len", l1, 24);
    check("t3_f1_bits", int'(b1[11:0]), 'hD4A);
    check("t3_start_on_end", e1, 0);
    check("t3_f2_len", l2, 24);
    check("t3_f2_bits", int'(b2[11:0]), 'hC78);

    // FIFO fill with valid held for 6 cycles, div=15
    @(negedge clk); baud_div = 16'd15; parity_en = 1'b0; stop2 = 1'b0;
    fork
      begin
        @(negedge clk); bus.tx_valid = 1'b1;
        for (int i = 1; i <= 6; i++) begin
          bus.tx_data = 8'(8'h11 * i);
          @(negedge clk);
        end
        bus.tx_valid = 1'b0;
        check("t4_count_full", fifo_count, 4);
        check("t4_ready_full", bus.tx_ready, 0);
      end
      begin
        for (int i = 0; i < 5; i++) begin
          run_frame(i != 0, 15, l1, b1, w1);
          check("t4_len", l1, 160);
          check("t4_bits", int'(b1[9:0]), 'h200 | ((8'h11 * (i + 1)) << 1));
        end
        check("t4_idle_after_5", tx_busy, 0);
      end
    join

    // baud change mid-frame
    @(negedge clk); baud_div = 16'd3;
    fork
      begin
        push1(8'h0F);
        repeat (6) @(negedge clk);
        baud_div = 16'd7;
        push1(8'hF0);
      end
      begin
        run_frame(0, 3, l1, b1, w1);
        run_frame(1, 7, l2, b2, w2);
      end
    join
    check("t5_f1_len", l1, 40);
    check("t5_f1_bits", int'(b1[9:0]), 'h21E);
    check("t5_f2_len", l2, 80);
    check("t5_f2_bits", int'(b2[9:0]), 'h3E0);

    // reset mid-DATA with two words queued
    @(negedge clk); baud_div = 16'd3;
    @(negedge clk); bus.tx_valid = 1'b1; bus.tx_data = 8'h81;
    @(negedge clk); bus.tx_data = 8'h42;
    @(negedge clk); bus.tx_data = 8'h24;
    @(negedge clk); bus.tx_valid = 1'b0;
    check("t6_count_before", fifo_count, 2);
    repeat (10) @(negedge clk);
    check("t6_busy_before", tx_busy, 1);
    reset = 1'b1;
    #1;
    check("t6_tx_async", tx, 1);
    check("t6_count_async", fifo_count, 0);
    check("t6_busy_async", tx_busy, 0);
    @(posedge clk); #1;
    check("t6_tx_next", tx, 1);
    check("t6_ready_next", bus.tx_ready, 1);
    @(negedge clk); reset = 1'b0;
    n_end = 0; n_low = 0;
    for (int k = 0; k < 200; k++) begin
      @(posedge clk); #1;
      if (tx_end === 1'b1) n_end++;
      if (tx !== 1'b1) n_low++;
    end
    check("t6_no_end", n_end, 0);
    check("t6_no_frame", n_low, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
